// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Operation codes follow the RV32M funct3 encoding.
package muldiv_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = $clog2(XLEN);

   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_e;

   localparam logic [XLEN-1:0] DIV0_QUOT = '1;
   localparam logic [XLEN-1:0] OVF_QUOT  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] OVF_REM   = '0;
   localparam logic [XLEN-1:0] NEG_ONE   = '1;

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: signedness decode, magnitudes,
// result sign, and detection of the divide-by-zero / overflow shortcuts.
module muldiv_operand_prep
   import muldiv_pkg::*;
#(
   parameter int unsigned n = XLEN
) (
   input  logic [2:0]   i_funct3,
   input  logic [n-1:0] i_rs1,
   input  logic [n-1:0] i_rs2,
   output logic [n-1:0] o_a_mag,
   output logic [n-1:0] o_b_mag,
   output logic         o_neg,
   output logic         o_is_div,
   output logic         o_fast,
   output logic [n-1:0] o_fast_data
);

   op_e  w_op;
   logic w_signed_a;
   logic w_signed_b;
   logic w_a_neg;
   logic w_b_neg;
   logic w_div0;
   logic w_ovf;

   assign w_op = op_e'(i_funct3);

   always_comb begin
      w_signed_a = 1'b0;
      w_signed_b = 1'b0;
      case (w_op)
         MULH:     begin w_signed_a = 1'b1; w_signed_b = 1'b1; end
         MULHSU:   w_signed_a = 1'b1;
         DIV, REM: begin w_signed_a = 1'b1; w_signed_b = 1'b1; end
         default:  ;
      endcase
   end

   assign w_a_neg  = w_signed_a & i_rs1[n-1];
   assign w_b_neg  = w_signed_b & i_rs2[n-1];
   assign o_a_mag  = w_a_neg ? ('0 - i_rs1) : i_rs1;
   assign o_b_mag  = w_b_neg ? ('0 - i_rs2) : i_rs2;
   assign o_is_div = i_funct3[2];

   // Remainder takes the dividend's sign; everything else takes the xor.
   assign o_neg = (w_op == REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

   assign w_div0 = o_is_div & (i_rs2 == '0);
   assign w_ovf  = ((w_op == DIV) || (w_op == REM)) &
                   (i_rs1 == OVF_QUOT) & (i_rs2 == NEG_ONE);
   assign o_fast = w_div0 | w_ovf;

   always_comb begin
      o_fast_data = '0;
      if (w_div0)
         o_fast_data = i_funct3[1] ? i_rs1 : DIV0_QUOT;
      else if (w_ovf)
         o_fast_data = i_funct3[1] ? OVF_REM : OVF_QUOT;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: one shift-add / shift-subtract step per cycle,
// start/busy/done handshake, result delivered on the register-file write port.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned n       = XLEN,
   parameter int unsigned address = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               flush_i,
   input  logic [2:0]         funct3_i,
   input  logic [n-1:0]       rs1_data_i,
   input  logic [n-1:0]       rs2_data_i,
   input  logic [address-1:0] rd_addr_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [n-1:0]       rd_data_o,
   output logic [address-1:0] rd_addr_o,
   output logic               rd_wr_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(n - 1);

   state_e             r_state;
   state_e             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [n-1:0]       r_hi;
   logic [n-1:0]       r_lo;
   logic [n-1:0]       r_b;
   op_e                r_op;
   logic               r_is_div;
   logic               r_neg;
   logic [address-1:0] r_rd_pend;
   logic [n-1:0]       r_rd_data;
   logic [address-1:0] r_rd_addr;

   logic [n-1:0]       w_a_mag;
   logic [n-1:0]       w_b_mag;
   logic               w_neg;
   logic               w_is_div;
   logic               w_fast;
   logic [n-1:0]       w_fast_data;
   logic               w_accept;

   logic [n:0]         w_mul_sum;
   logic [n:0]         w_shift;
   logic [n:0]         w_trial;
   logic [2*n-1:0]     w_prod_fix;
   logic [n-1:0]       w_fix_result;

   muldiv_operand_prep #(.n(n)) u_prep (
      .i_funct3    (funct3_i),
      .i_rs1       (rs1_data_i),
      .i_rs2       (rs2_data_i),
      .o_a_mag     (w_a_mag),
      .o_b_mag     (w_b_mag),
      .o_neg       (w_neg),
      .o_is_div    (w_is_div),
      .o_fast      (w_fast),
      .o_fast_data (w_fast_data)
   );

   assign w_accept = (r_state == IDLE) & start_i & ~flush_i;

   always_comb begin
      w_next = r_state;
      if (flush_i) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (start_i) w_next = w_fast ? DONE : CALC;
            CALC:    if (r_cnt == CNT_LAST) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   // r_hi/r_lo hold {product high, multiplier} for multiply and
   // {partial remainder, dividend/quotient} for divide.
   assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
   assign w_shift   = {r_hi, r_lo[n-1]};
   assign w_trial   = w_shift - {1'b0, r_b};

   assign w_prod_fix = r_neg ? ('0 - {r_hi, r_lo}) : {r_hi, r_lo};

   always_comb begin
      w_fix_result = '0;
      case (r_op)
         MUL:                  w_fix_result = w_prod_fix[n-1:0];
         MULH, MULHSU, MULHU:  w_fix_result = w_prod_fix[2*n-1:n];
         DIV, DIVU:            w_fix_result = r_neg ? ('0 - r_lo) : r_lo;
         REM, REMU:            w_fix_result = r_neg ? ('0 - r_hi) : r_hi;
         default:              w_fix_result = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_b       <= '0;
         r_op      <= MUL;
         r_is_div  <= 1'b0;
         r_neg     <= 1'b0;
         r_rd_pend <= '0;
         r_rd_data <= '0;
         r_rd_addr <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_op      <= op_e'(funct3_i);
            r_is_div  <= w_is_div;
            r_neg     <= w_neg;
            r_b       <= w_b_mag;
            r_hi      <= '0;
            r_lo      <= w_a_mag;
            r_cnt     <= '0;
            r_rd_pend <= rd_addr_i;
            if (w_fast) begin
               r_rd_data <= w_fast_data;
               r_rd_addr <= rd_addr_i;
            end
         end else if ((r_state == CALC) && !flush_i) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_div) begin
               r_hi <= w_trial[n] ? w_shift[n-1:0] : w_trial[n-1:0];
               r_lo <= {r_lo[n-2:0], ~w_trial[n]};
            end else begin
               {r_hi, r_lo} <= {w_mul_sum, r_lo[n-1:1]};
            end
         end else if ((r_state == FIX) && !flush_i) begin
            r_rd_data <= w_fix_result;
            r_rd_addr <= r_rd_pend;
         end
      end
   end

   assign busy_o    = (r_state != IDLE);
   assign done_o    = (r_state == DONE);
   assign rd_wr_o   = done_o & (r_rd_addr != '0);
   assign rd_data_o = r_rd_data;
   assign rd_addr_o = r_rd_addr;

endmodule
